// File: rtl/led_anim_pkg.sv
// rtl/led_anim_pkg.sv - shared constants for the LED animator (optional build macro: LED_ACTIVE_LOW_EN)
package led_anim_pkg;

  localparam int LED_W = 8;

  localparam logic [1:0] MODE_WALK_L   = 2'd0;
  localparam logic [1:0] MODE_WALK_R   = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_BAR      = 2'd3;

  localparam logic [LED_W-1:0] START_WALK_L   = 8'h01;
  localparam logic [LED_W-1:0] START_WALK_R   = 8'h80;
  localparam logic [LED_W-1:0] START_PINGPONG = 8'h01;
  localparam logic [LED_W-1:0] START_BAR      = 8'h00;

  // Pattern shown on the first cycle of a (re)started animation
  function automatic logic [LED_W-1:0] start_pattern(input logic [1:0] m);
    case (m)
      MODE_WALK_L:   start_pattern = START_WALK_L;
      MODE_WALK_R:   start_pattern = START_WALK_R;
      MODE_PINGPONG: start_pattern = START_PINGPONG;
      default:       start_pattern = START_BAR;
    endcase
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// rtl/led_step_timer.sv - prescaler producing a one-cycle step pulse every STEP_CYCLES clocks
module led_step_timer #(
  parameter int STEP_CYCLES = 25,
  parameter int CNT_W       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic step
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign step = (count == LAST);

  // Count 0..STEP_CYCLES-1 and wrap; clear restarts the step from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || step) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_animator.sv
// rtl/led_animator.sv - 8-LED pattern engine; define LED_ACTIVE_LOW_EN to invert led_out
module led_animator
  import led_anim_pkg::*;
#(
  parameter int STEP_CYCLES = 25,
  parameter int CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led_out
);

  logic [1:0]       mode_q;
  logic             started;
  logic             dir;      // 0 = left / fill, 1 = right / drain
  logic [LED_W-1:0] pattern;
  logic             hold;
  logic             step;

  // hold is written as a positive match so an unknown mode falls into the
  // load branch and the start pattern of the now-known mode is reloaded
  assign hold = started && (mode == mode_q);

  led_step_timer #(
    .STEP_CYCLES(STEP_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(~hold),
    .step (step)
  );

  // Mode latch plus pattern next-state; a mode (re)load beats a coincident step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_WALK_L;
      started <= 1'b0;
      dir     <= 1'b0;
      pattern <= '0;
    end else begin
      mode_q  <= mode;
      started <= 1'b1;
      if (hold) begin
        if (step) begin
          case (mode_q)
            MODE_WALK_L: pattern <= {pattern[6:0], pattern[7]};
            MODE_WALK_R: pattern <= {pattern[0], pattern[7:1]};
            MODE_PINGPONG: begin
              if (!dir) begin
                pattern <= pattern << 1;
                if (pattern == 8'h40) dir <= 1'b1;
              end else begin
                pattern <= pattern >> 1;
                if (pattern == 8'h02) dir <= 1'b0;
              end
            end
            default: begin
              if (!dir) begin
                pattern <= {pattern[6:0], 1'b1};
                if (pattern == 8'h7F) dir <= 1'b1;
              end else begin
                pattern <= {1'b0, pattern[7:1]};
                if (pattern == 8'h01) dir <= 1'b0;
              end
            end
          endcase
        end
      end else begin
        pattern <= start_pattern(mode);
        dir     <= 1'b0;
      end
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led_out = ~pattern;
`else
  assign led_out = pattern;
`endif

endmodule

// File: tb/tb_led_animator.sv
// tb/tb_led_animator.sv - self-checking bench for led_animator (honours LED_ACTIVE_LOW_EN)
module tb_led_animator;

  localparam int STEP = 25;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] led_out;

  int tests_run;
  int tests_failed;

  // Reference model state: sequence position within a step table
  logic [1:0] m_mode;
  bit         m_started;
  int         m_cyc;
  int         m_idx;

  typedef struct {
    logic [1:0] mode;
    int         ticks;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  led_animator dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .led_out(led_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Sequence value at position i of the repeating pattern for mode m
  function automatic logic [7:0] seq_val(input logic [1:0] m, input int i);
    int v;
    case (m)
      2'd0: v = 1 << i;
      2'd1: v = 128 >> i;
      2'd2: v = (i <= 7) ? (1 << i) : (1 << (14 - i));
      default: v = (i <= 8) ? ((1 << i) - 1) : (255 >> (i - 8));
    endcase
    return v[7:0];
  endfunction

  function automatic int period(input logic [1:0] m);
    return (m < 2) ? 8 : (m == 2) ? 14 : 16;
  endfunction

  function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef LED_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [7:0] model_out();
    return m_started ? pol(seq_val(m_mode, m_idx)) : pol(8'h00);
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_mode    = 2'd0;
    m_cyc     = 0;
    m_idx     = 0;
  endtask

  task automatic model_edge(input logic r, input logic [1:0] m);
    if (r) begin
      model_reset();
    end else if (!m_started || m != m_mode) begin
      m_started = 1;
      m_mode    = m;
      m_cyc     = 0;
      m_idx     = 0;
    end else if (m_cyc == STEP - 1) begin
      m_cyc = 0;
      m_idx = (m_idx + 1) % period(m_mode);
    end else begin
      m_cyc++;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: led_out=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the edge, DUT compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_edge(rst, mode);
    @(negedge clk);
    check("model", led_out, model_out());
  endtask

  task automatic add(input logic [1:0] m, input int n, input logic [7:0] e);
    vec_t v;
    v.mode = m; v.ticks = n; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_reset();

    add(2'd3, 1,        8'h00);
    add(2'd3, STEP,     8'h01);
    add(2'd3, STEP,     8'h03);
    add(2'd3, STEP,     8'h07);
    add(2'd0, 1,        8'h01);
    add(2'd0, 3*STEP,   8'h08);
    add(2'd1, 1,        8'h80);
    add(2'd1, STEP-1,   8'h80);
    add(2'd1, 1,        8'h40);
    add(2'd2, 1,        8'h01);
    add(2'd2, 7*STEP,   8'h80);
    add(2'd2, STEP,     8'h40);
    add(2'd2, 6*STEP,   8'h01);
    add(2'd2, STEP,     8'h02);
    add(2'd3, 1,        8'h00);
    add(2'd3, 8*STEP,   8'hFF);
    add(2'd3, STEP,     8'h7F);
    add(2'd3, 7*STEP,   8'h00);
    add(2'd3, STEP,     8'h01);

    // Reset held with an undefined mode
    rst  = 1'b1;
    mode = 2'bxx;
    #5;
    check("rst_hold_a", led_out, pol(8'h00));
    #20;
    check("rst_hold_b", led_out, pol(8'h00));
    @(negedge clk);
    check("rst_hold_c", led_out, pol(8'h00));
    mode = 2'd3;
    rst  = 1'b0;

    // Table-driven pass
    foreach (vecs[k]) begin
      mode = vecs[k].mode;
      repeat (vecs[k].ticks) tick();
      check($sformatf("table%0d", k), led_out, pol(vecs[k].exp));
    end

    // Async reset mid-animation at 3F, off the clock edge
    repeat (5*STEP) tick();
    check("pre_rst_3f", led_out, pol(8'h3F));
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst", led_out, pol(8'h00));
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("restart_m3_load", led_out, pol(8'h00));
    repeat (STEP) tick();
    check("restart_m3_step", led_out, pol(8'h01));

    // Reset then restart in walk-right
    mode = 2'd1;
    rst  = 1'b1;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("restart_m1_load", led_out, pol(8'h80));
    repeat (STEP) tick();
    check("restart_m1_step", led_out, pol(8'h40));

    // Randomised mode changes, durations and occasional resets
    for (int s = 0; s < 40; s++) begin
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        model_reset();
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 400)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
